mem_refill_arbiter: RTL and testbench
=====================================

// Module: mem_refill_arbiter
// PURPOSE
//  Shares the single main-memory read port between two cache refill requesters
//  (port 0: instruction cache, port 1: data cache).
//  - Grants one requester at a time, round-robin on conflict.
//  - Issues one burst request per grant and steers the returning beats to the owner.
//  - Sits between the caches' miss state machines and the main-memory controller.
// PARAMETERS
//  ADDR_W     32   word-address width, requester and memory side
//  DATA_W     64   beat (word) width
//  BURST_LEN  4    beats per refill; power of 2, >= 2
//  TIMEOUT    255  max idle cycles between beats before abort; range 1..2^16-1
// PORTS
//  clock        in   1       rising-edge clock
//  reset        in   1       asynchronous, active-low
//  req0/req1    in   1       refill request; held high until matching gnt pulse
//  addr0/addr1  in   ADDR_W  word address of the missing word
//  gnt0/gnt1    out  1       one-cycle pulse: request accepted
//  rvalid0/1    out  1       rdata holds a beat for this requester
//  rlast0/1     out  1       with rvalid: final beat of the burst
//  err0/err1    out  1       one-cycle pulse: burst aborted on timeout
//  rdata        out  DATA_W  beat data, shared by both requesters
//  mem_req      out  1       burst request to memory
//  mem_addr     out  ADDR_W  burst base address (burst-aligned)
//  mem_ready    in   1       memory accepts mem_req this cycle
//  mem_rvalid   in   1       mem_rdata holds a valid beat
//  mem_rdata    in   DATA_W  beat data from memory
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr_last=1 (port 0 wins the first tie), beat_cnt=0.
//  FSM IDLE -> ISSUE -> BURST -> IDLE.
//  IDLE:
//  - Only req0: own=0. Only req1: own=1. Both: own = ~rr_last.
//  - Latch base = addrN with low log2(BURST_LEN) bits cleared.
//  - Pulse gntN in the same cycle (registered, visible next cycle); go to ISSUE.
//  ISSUE:
//  - mem_req=1, mem_addr=base; both held stable until mem_ready=1.
//  - Handshake cycle -> BURST with beat_cnt=0, timer=0.
//  - A grant is never revoked.
//  BURST, on each mem_rvalid:
//  - Next cycle: rdata=mem_rdata, rvalid_own=1; timer clears.
//  - beat_cnt increments.
//  - Beat BURST_LEN-1 also sets rlast_own=1, rr_last<=own, state -> IDLE.
//  - Latency mem_rvalid -> rvalidN is exactly 1 cycle; the non-owner's rvalid stays 0.
//  BURST, no beat: timer increments.
//  - timer==TIMEOUT: errN pulse, no rlast, rr_last<=own, -> IDLE; late beats ignored.
//  Ignored inputs:
//  - mem_rvalid in IDLE/ISSUE, and in the same cycle mem_ready rises.
//  - reqN changes after gnt: the burst always runs to completion or timeout.
//  Earliest re-arbitration is the cycle after rlast/err.
//  - Back-to-back grant costs 1 idle cycle; a waiting requester is served next (no starvation).
//  beat_cnt and rdata are not cleared between bursts; only rvalid/rlast/gnt/err return to 0.
//  Reset asserted mid-burst: immediate return to reset values; the memory side must also be reset.
// TESTING
//  req0 @addr=0x1237, mem_ready next cycle, beats A,B,C,D contiguous
//    -> gnt0 pulse; mem_addr=0x1234; rvalid0 x4, data A..D; rlast0 on D only.
//  req0+req1 same cycle after reset
//    -> port 0 served first, port 1 granted 1 cycle after rlast0.
//  Repeat with both held
//    -> grants alternate 1,0,1.
//  mem_ready held low 10 cycles
//    -> mem_req/mem_addr stable, no gnt re-pulse, no rvalid.
//  Beats with gaps of 0,3,0 cycles, TIMEOUT=4
//    -> all 4 beats delivered, no err.
//  TIMEOUT=4, only 2 beats then silence
//    -> err pulse 4 cycles after the 2nd beat, no rlast; a late beat produces no rvalid.
//  reset low mid-BURST
//    -> all outputs 0 next edge; a fresh req1 is granted normally.
//  Random req/mem stalls, 10k cycles
//    -> every gnt followed by exactly BURST_LEN rvalids or one err; the owner's data only.

Source files
------------

// File: rtl/mem_refill_arbiter.sv
// Arbitrates the main-memory read port between the instruction-cache (port 0)
// and data-cache (port 1) refill engines, one burst per grant, round-robin on conflict.
module mem_refill_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int BURST_LEN = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic              rlast0,
   output logic              rlast1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(BURST_LEN);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] BURST = 2'd2;

   localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BURST_LEN - 1);
   localparam logic [15:0]       TIMER_MAX  = 16'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BURST_LEN - 1);

   logic [1:0]        state;
   logic              own;
   logic              rr_last;
   logic [ADDR_W-1:0] base;
   logic [CNT_W-1:0]  beat_cnt;
   logic [15:0]       timer;

   logic              pick;
   logic [ADDR_W-1:0] pick_addr;

   // On a tie the port that was not served last wins.
   always_comb begin
      pick      = 1'b0;
      pick_addr = '0;
      if (req0 && req1) begin
         pick = ~rr_last;
      end else begin
         pick = req1;
      end
      pick_addr = pick ? addr1 : addr0;
   end

   assign mem_req  = (state == ISSUE);
   assign mem_addr = base;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         own      <= 1'b0;
         rr_last  <= 1'b1;
         base     <= '0;
         beat_cnt <= '0;
         timer    <= '0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         rvalid0  <= 1'b0;
         rvalid1  <= 1'b0;
         rlast0   <= 1'b0;
         rlast1   <= 1'b0;
         err0     <= 1'b0;
         err1     <= 1'b0;
         rdata    <= '0;
      end else begin
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rlast0  <= 1'b0;
         rlast1  <= 1'b0;
         err0    <= 1'b0;
         err1    <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  own   <= pick;
                  base  <= pick_addr & ALIGN_MASK;
                  gnt0  <= ~pick;
                  gnt1  <= pick;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_ready) begin
                  beat_cnt <= '0;
                  timer    <= '0;
                  state    <= BURST;
               end
            end
            BURST: begin
               if (mem_rvalid) begin
                  rdata    <= mem_rdata;
                  rvalid0  <= ~own;
                  rvalid1  <= own;
                  timer    <= '0;
                  beat_cnt <= beat_cnt + 1'b1;
                  if (beat_cnt == LAST_BEAT) begin
                     rlast0  <= ~own;
                     rlast1  <= own;
                     rr_last <= own;
                     state   <= IDLE;
                  end
               // Abort on the TIMEOUT-th consecutive empty cycle.
               end else if (timer == TIMER_MAX) begin
                  err0    <= ~own;
                  err1    <= own;
                  rr_last <= own;
                  state   <= IDLE;
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Randomised and directed bench for mem_refill_arbiter, compared every cycle
// against a transaction-level model of the arbitration and burst rules.
module tb_mem_refill_arbiter;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int BL = 4;
   localparam int TO = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic          gnt0, gnt1, rvalid0, rvalid1, rlast0, rlast1, err0, err1;
   logic [DW-1:0] rdata;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ready = 1'b0, mem_rvalid = 1'b0;
   logic [DW-1:0] mem_rdata = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit sticky = 1'b0;

   mem_refill_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .TIMEOUT(TO)
   ) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rlast0(rlast0), .rlast1(rlast1), .err0(err0), .err1(err1),
      .rdata(rdata), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transaction-level reference: one outstanding refill at a time.
   typedef struct packed {
      logic          active;
      logic          accepted;
      logic          owner;
      logic          last;
      logic [AW-1:0] base;
      int            beats;
      int            quiet;
      logic [1:0]    gnt, rv, rl, err;
      logic [DW-1:0] rdata;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t s;
      s = '0;
      s.last = 1'b1;
      return s;
   endfunction

   function automatic model_t model_step(model_t s, logic r0, logic r1, logic [AW-1:0] a0,
                                         logic [AW-1:0] a1, logic rdy, logic mv,
                                         logic [DW-1:0] rd);
      model_t n;
      n = s;
      n.gnt = '0; n.rv = '0; n.rl = '0; n.err = '0;
      if (!s.active) begin
         if (r0 || r1) begin
            n.owner = (r0 && r1) ? !s.last : r1;
            n.base  = AW'(((n.owner ? a1 : a0) / BL) * BL);
            n.gnt[n.owner] = 1'b1;
            n.active   = 1'b1;
            n.accepted = 1'b0;
         end
      end else if (!s.accepted) begin
         if (rdy) begin
            n.accepted = 1'b1;
            n.beats = 0;
            n.quiet = 0;
         end
      end else if (mv) begin
         n.rdata = rd;
         n.rv[s.owner] = 1'b1;
         n.beats = s.beats + 1;
         n.quiet = 0;
         if (n.beats == BL) begin
            n.rl[s.owner] = 1'b1;
            n.last = s.owner;
            n.active = 1'b0;
         end
      end else begin
         n.quiet = s.quiet + 1;
         if (n.quiet == TO) begin
            n.err[s.owner] = 1'b1;
            n.last = s.owner;
            n.active = 1'b0;
         end
      end
      return n;
   endfunction

   initial m = model_reset();

   always @(posedge clock or negedge reset) begin
      if (!reset) m <= model_reset();
      else m <= model_step(m, req0, req1, addr0, addr1, mem_ready, mem_rvalid, mem_rdata);
   end

   logic [1:0] d_gnt, d_rv, d_rl, d_err;
   assign d_gnt = {gnt1, gnt0};
   assign d_rv  = {rvalid1, rvalid0};
   assign d_rl  = {rlast1, rlast0};
   assign d_err = {err1, err0};

   int sb_cnt [2] = '{0, 0};

   always @(negedge clock) begin
      check("gnt",    64'(d_gnt), 64'(m.gnt));
      check("rvalid", 64'(d_rv),  64'(m.rv));
      check("rlast",  64'(d_rl),  64'(m.rl));
      check("err",    64'(d_err), 64'(m.err));
      check("rdata",  rdata, m.rdata);
      check("mem_req", 64'(mem_req), 64'(m.active && !m.accepted));
      if (m.active && !m.accepted) check("mem_addr", 64'(mem_addr), 64'(m.base));
      if (reset) begin
         for (int p = 0; p < 2; p++) begin
            if (d_rv[p] && d_rl[p]) check("burst_beats", 64'(sb_cnt[p] + 1), 64'(BL));
            if (d_err[p]) check("err_short_burst", 64'(sb_cnt[p] < BL), 64'd1);
            if (d_gnt[p]) sb_cnt[p] <= 0;
            else if (d_rv[p]) sb_cnt[p] <= sb_cnt[p] + 1;
         end
      end else begin
         sb_cnt <= '{0, 0};
      end
   end

   task automatic cycle();
      @(negedge clock);
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      if (!sticky) begin
         if (gnt0) req0 = 1'b0;
         if (gnt1) req1 = 1'b0;
      end
   endtask

   task automatic wait_grant(output int n);
      n = 0;
      while (!(gnt0 || gnt1) && n < 40) begin
         cycle();
         n++;
      end
      check("grant_seen", 64'(gnt0 || gnt1), 64'd1);
   endtask

   task automatic run_burst(input logic [DW-1:0] d, output int port, output int gcyc,
                            output int rcyc);
      int n;
      wait_grant(n);
      port = gnt1 ? 1 : 0;
      gcyc = cyc;
      mem_ready = 1'b1;
      cycle();
      for (int b = 0; b < BL; b++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = d + DW'(b);
         cycle();
      end
      check("burst_rlast", 64'(port == 1 ? rlast1 : rlast0), 64'd1);
      check("burst_last_data", rdata, d + DW'(BL - 1));
      rcyc = cyc;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt"},   64'({gnt1, gnt0}), 64'd0);
      check({tag, "_rvalid"}, 64'({rvalid1, rvalid0}), 64'd0);
      check({tag, "_rlast"}, 64'({rlast1, rlast0}), 64'd0);
      check({tag, "_err"},   64'({err1, err0}), 64'd0);
      check({tag, "_rdata"}, rdata, 64'd0);
      check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
      check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      #2;
      reset = 1'b0;
      req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
      @(negedge clock);
      #2;
      reset = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] dat [4];
      int n, port, gcyc, rcyc, prev_rcyc, seen;
      int exp_ports [4];
      logic [6:0] pat;
      int quiet_left;

      dat = '{64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B,
              64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D};
      exp_ports = '{0, 1, 0, 1};

      // Reset state
      @(negedge clock);
      check_all_zero("reset");
      #2 reset = 1'b1;
      cycle();

      // Single port-0 refill with contiguous beats
      req0 = 1'b1; addr0 = 32'h0000_1237;
      wait_grant(n);
      check("t1_grant_latency", 64'(n), 64'd1);
      check("t1_gnt0", 64'(gnt0), 64'd1);
      check("t1_gnt1", 64'(gnt1), 64'd0);
      check("t1_mem_req", 64'(mem_req), 64'd1);
      check("t1_mem_addr", 64'(mem_addr), 64'h1234);
      mem_ready = 1'b1;
      cycle();
      check("t1_gnt_once", 64'(gnt0), 64'd0);
      check("t1_mem_req_drop", 64'(mem_req), 64'd0);
      for (int b = 0; b < 4; b++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = dat[b];
         cycle();
         check("t1_rvalid0", 64'(rvalid0), 64'd1);
         check("t1_rvalid1", 64'(rvalid1), 64'd0);
         check("t1_rdata", rdata, dat[b]);
         check("t1_rlast0", 64'(rlast0), 64'(b == 3));
      end
      cycle();
      check("t1_rvalid_end", 64'(rvalid0), 64'd0);
      check("t1_rlast_end", 64'(rlast0), 64'd0);

      // Both requesters held high from reset: grants alternate 0,1,0,1
      do_reset();
      cycle();
      sticky = 1'b1;
      req0 = 1'b1; addr0 = 32'h0000_2005;
      req1 = 1'b1; addr1 = 32'h0000_300E;
      prev_rcyc = 0;
      for (int k = 0; k < 4; k++) begin
         run_burst(64'h1000 * DW'(k + 1), port, gcyc, rcyc);
         check("rr_order", 64'(port), 64'(exp_ports[k]));
         if (k > 0) check("regrant_gap", 64'(gcyc - prev_rcyc), 64'd1);
         prev_rcyc = rcyc;
      end
      sticky = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      cycle();

      // mem_ready withheld for 10 cycles, then beats with gaps 0,3,0
      req1 = 1'b1; addr1 = 32'h0000_ABCF;
      wait_grant(n);
      check("t4_mem_addr", 64'(mem_addr), 64'hABCC);
      for (int i = 0; i < 10; i++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 64'hDEAD_BEEF;
         cycle();
         check("t4_mem_req_held", 64'(mem_req), 64'd1);
         check("t4_mem_addr_held", 64'(mem_addr), 64'hABCC);
         check("t4_no_regrant", 64'({gnt1, gnt0}), 64'd0);
         check("t4_no_rvalid", 64'({rvalid1, rvalid0}), 64'd0);
      end
      mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hBAD0;
      cycle();
      check("t4_handshake_beat_ignored", 64'(rvalid1), 64'd0);
      pat = 7'b1100011;
      seen = 0;
      n = 0;
      for (int i = 0; i < 7; i++) begin
         if (pat[6 - i]) begin
            mem_rvalid = 1'b1;
            mem_rdata  = dat[n];
            n++;
         end
         cycle();
         if (rvalid1) seen++;
         check("t5_no_err", 64'({err1, err0}), 64'd0);
      end
      check("t5_beats", 64'(seen), 64'd4);
      check("t5_rlast1", 64'(rlast1), 64'd1);
      check("t5_rdata", rdata, dat[3]);
      cycle();

      // Two beats then silence: abort after TIMEOUT empty cycles
      req0 = 1'b1; addr0 = 32'h0000_0041;
      wait_grant(n);
      mem_ready = 1'b1;
      cycle();
      mem_rvalid = 1'b1; mem_rdata = dat[0];
      cycle();
      mem_rvalid = 1'b1; mem_rdata = dat[1];
      cycle();
      check("t6_second_beat", 64'(rvalid0), 64'd1);
      n = 0;
      while (!err0 && n < 20) begin
         cycle();
         n++;
         check("t6_no_rlast", 64'(rlast0), 64'd0);
      end
      check("t6_err_delay", 64'(n), 64'd4);
      check("t6_err_owner_only", 64'(err1), 64'd0);
      mem_rvalid = 1'b1; mem_rdata = dat[2];
      cycle();
      check("t6_late_beat_dropped", 64'({rvalid1, rvalid0}), 64'd0);
      check("t6_err_pulse", 64'(err0), 64'd0);

      // Reset mid-burst, then a fresh port-1 request
      req1 = 1'b1; addr1 = 32'h0000_5553;
      wait_grant(n);
      mem_ready = 1'b1;
      cycle();
      mem_rvalid = 1'b1; mem_rdata = dat[3];
      cycle();
      check("t7_mid_burst", 64'(rvalid1), 64'd1);
      #2;
      reset = 1'b0;
      req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
      #1;
      check_all_zero("t7_async_reset");
      @(negedge clock);
      #2 reset = 1'b1;
      cycle();
      req1 = 1'b1; addr1 = 32'h0000_0077;
      wait_grant(n);
      check("t7_regrant_latency", 64'(n), 64'd1);
      check("t7_gnt1", 64'(gnt1), 64'd1);
      check("t7_mem_addr", 64'(mem_addr), 64'h74);
      mem_ready = 1'b1;
      cycle();
      for (int b = 0; b < BL; b++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = dat[b];
         cycle();
      end
      check("t7_rlast1", 64'(rlast1), 64'd1);

      // Random traffic with memory stalls and silences
      quiet_left = 0;
      for (int i = 0; i < 10000; i++) begin
         if (!req0 && $urandom_range(0, 3) == 0) begin
            req0 = 1'b1;
            addr0 = $urandom;
         end
         if (!req1 && $urandom_range(0, 3) == 0) begin
            req1 = 1'b1;
            addr1 = $urandom;
         end
         if (quiet_left > 0) quiet_left--;
         else if ($urandom_range(0, 49) == 0) quiet_left = 6;
         mem_ready  = ($urandom_range(0, 2) == 0);
         mem_rvalid = (quiet_left == 0) && ($urandom_range(0, 9) < 7);
         mem_rdata  = {$urandom, $urandom};
         cycle();
      end
      req0 = 1'b0; req1 = 1'b0;
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
